// File: rtl/hp35_wb_dbg_regs.sv
// Wishbone-classic debug register bank for hp35_core: control words, status snapshots,
// sticky edge events with interrupt, and an event counter. Optional macro: HP35_DBG_LA_OVERRIDE_EN.
module hp35_wb_dbg_regs #(
  parameter int unsigned NCTRL     = 4,
  parameter int unsigned NSTAT     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  input  logic [NSTAT*32-1:0]   stat_i,
  input  logic                  evt_i,
`ifdef HP35_DBG_LA_OVERRIDE_EN
  input  logic [31:0]           la_data_in,
  input  logic [31:0]           la_oenb,
`endif
  output logic [NCTRL*32-1:0]   ctrl_o,
  output logic                  irq_o
);

  localparam logic [31:0] ID_VALUE = 32'h4850_3335;
  localparam logic [5:0]  IDX_ID     = 6'd0;
  localparam logic [5:0]  IDX_SNAP   = 6'd1;
  localparam logic [5:0]  IDX_STICKY = 6'd2;
  localparam logic [5:0]  IDX_COUNT  = 6'd3;
  localparam logic [5:0]  IDX_MASK   = 6'd4;

  logic [31:0] ctrl_q   [NCTRL];
  logic [31:0] shadow_q [NSTAT];
  logic [31:0] sticky_q;
  logic [31:0] mask_q;
  logic [31:0] count_q;
  logic [31:0] stat_q;
  logic [31:0] stat_d1_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        irq_q;

  logic        hit;
  logic        accept;
  logic        wr;
  logic [5:0]  idx;
  logic [31:0] rd_data;
  logic [31:0] rise;
  logic [31:0] sticky_clr;
  logic        unused_adr;

  assign hit        = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign accept     = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign wr         = accept & wbs_we_i;
  assign idx        = wbs_adr_i[7:2];
  assign unused_adr = ^{wbs_adr_i[11:8], wbs_adr_i[1:0]};

  // Edge detect runs on a registered copy so a rise shows up in STICKY one edge later.
  assign rise       = stat_q & ~stat_d1_q;
  assign sticky_clr = (wr && idx == IDX_STICKY) ? wbs_dat_i : '0;

  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_ID:     rd_data = ID_VALUE;
      IDX_STICKY: rd_data = sticky_q;
      IDX_COUNT:  rd_data = count_q;
      IDX_MASK:   rd_data = mask_q;
      default:    rd_data = '0;
    endcase
    for (int unsigned i = 0; i < NCTRL; i++) begin
      if (idx == 6'(16 + i)) rd_data = ctrl_q[i];
    end
    for (int unsigned i = 0; i < NSTAT; i++) begin
      if (idx == 6'(32 + i)) rd_data = shadow_q[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
      sticky_q  <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      stat_q    <= stat_i[31:0];
      stat_d1_q <= stat_i[31:0];
      for (int unsigned i = 0; i < NCTRL; i++) ctrl_q[i] <= '0;
      for (int unsigned i = 0; i < NSTAT; i++) shadow_q[i] <= '0;
    end else begin
      ack_q     <= accept;
      dat_q     <= accept ? rd_data : '0;
      stat_q    <= stat_i[31:0];
      stat_d1_q <= stat_q;
      // Set has priority over write-1-to-clear on the same bit.
      sticky_q  <= (sticky_q & ~sticky_clr) | rise;
      irq_q     <= |(sticky_q & mask_q);

      if (wr && idx == IDX_COUNT) count_q <= '0;
      else if (evt_i)             count_q <= count_q + 32'd1;

      if (wr && idx == IDX_MASK) mask_q <= wbs_dat_i;

      if (wr && idx == IDX_SNAP && wbs_dat_i[0]) begin
        for (int unsigned i = 0; i < NSTAT; i++) shadow_q[i] <= stat_i[32*i +: 32];
      end

      for (int unsigned i = 0; i < NCTRL; i++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wr && idx == 6'(16 + i) && wbs_sel_i[b])
            ctrl_q[i][8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCTRL; i++) ctrl_o[32*i +: 32] = ctrl_q[i];
`ifdef HP35_DBG_LA_OVERRIDE_EN
    ctrl_o[31:0] = (la_oenb & ctrl_q[0]) | (~la_oenb & la_data_in);
`endif
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_hp35_wb_dbg_regs.sv
// Self-checking bench for hp35_wb_dbg_regs: directed steps mixed with $urandom data,
// checked against a register-level model of the bank.
module tb_hp35_wb_dbg_regs;
  localparam int unsigned NCTRL = 4;
  localparam int unsigned NSTAT = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cyc, stb, we;
  logic [3:0]           sel;
  logic [31:0]          adr, wdat;
  logic [31:0]          dat_o;
  logic                 ack;
  logic [NSTAT*32-1:0]  stat;
  logic                 evt;
  logic [NCTRL*32-1:0]  ctrl_o;
  logic                 irq;
`ifdef HP35_DBG_LA_OVERRIDE_EN
  logic [31:0]          la_data_in;
  logic [31:0]          la_oenb;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hp35_wb_dbg_regs #(.NCTRL(NCTRL), .NSTAT(NSTAT), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .stat_i    (stat),
    .evt_i     (evt),
`ifdef HP35_DBG_LA_OVERRIDE_EN
    .la_data_in(la_data_in),
    .la_oenb   (la_oenb),
`endif
    .ctrl_o    (ctrl_o),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One classic transfer; lat = cycles from drive to ack (0 = no ack within 8 cycles).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; rdata = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = n; rdata = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    xfer(1'b0, a, 32'h0, 4'hF, r, l);
    chk({tag, "_lat"}, 64'(l), 64'd1);
    chk(tag, 64'(r), 64'(exp));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int l;
    xfer(1'b1, a, d, s, r, l);
    chk("wr_lat", 64'(l), 64'd1);
  endtask

  task automatic pulse_evt(input int n);
    @(negedge clk); evt = 1'b1;
    repeat (n) @(negedge clk);
    evt = 1'b0;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  logic [31:0] ctrl_m [NCTRL];
  logic [31:0] snap_m [NSTAT];
  logic [31:0] r32, m32, rv;
  logic [3:0]  s4;
  int          lat, k, n;

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0;
    stat = '0; evt = 1'b0;
`ifdef HP35_DBG_LA_OVERRIDE_EN
    la_data_in = '0; la_oenb = '1;
`endif
    for (int i = 0; i < NCTRL; i++) ctrl_m[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_ctrl", 64'(ctrl_o[63:0]), 64'd0);

    rd("id", BASE + 32'h00, 32'h4850_3335);
    rd("count_rst", BASE + 32'h0C, 32'h0);

    // Byte-lane write from the plan.
    wr(BASE + 32'h44, 32'hDEAD_BEEF, 4'b0101);
    ctrl_m[1] = 32'h00AD_00EF;
    rd("ctrl1_lanes", BASE + 32'h44, 32'h00AD_00EF);
    chk("ctrl_o1", 64'(ctrl_o[63:32]), 64'h00AD_00EF);

    // Random control writes against a lane-merge model.
    for (int t = 0; t < 10; t++) begin
      k   = int'($urandom_range(NCTRL - 1, 0));
      s4  = 4'($urandom);
      r32 = $urandom;
      wr(BASE + 32'h40 + 32'(4 * k), r32, s4);
      ctrl_m[k] = (ctrl_m[k] & ~lane_mask(s4)) | (r32 & lane_mask(s4));
    end
    for (int i = 0; i < NCTRL; i++) begin
      rd("ctrl_rand", BASE + 32'h40 + 32'(4 * i), ctrl_m[i]);
      chk("ctrl_o_rand", 64'(ctrl_o[32*i +: 32]), 64'(ctrl_m[i]));
    end

    // Snapshot: word 2 fixed, others random; bit0=0 must not capture.
    @(negedge clk);
    for (int i = 0; i < NSTAT; i++) stat[32*i +: 32] = $urandom;
    stat[95:64] = 32'h1234_5678;
    for (int i = 0; i < NSTAT; i++) snap_m[i] = stat[32*i +: 32];
    wr(BASE + 32'h04, 32'h1, 4'hF);
    @(negedge clk);
    for (int i = 0; i < NSTAT; i++) stat[32*i +: 32] = $urandom;
    rd("snap_w2", BASE + 32'h88, 32'h1234_5678);
    wr(BASE + 32'h04, 32'hFFFF_FFFE, 4'hF);
    for (int i = 0; i < NSTAT; i++) rd("snap_hold", BASE + 32'h80 + 32'(4 * i), snap_m[i]);
    rd("snap_reads0", BASE + 32'h04, 32'h0);

    // Sticky / irq on bit 3.
    @(negedge clk); stat[31:0] = '0;
    repeat (3) @(negedge clk);
    wr(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'h10, 32'h8, 4'hF);
    rd("sticky_clear", BASE + 32'h08, 32'h0);
    repeat (2) @(negedge clk);
    chk("irq_idle", 64'(irq), 64'd0);
    @(negedge clk); stat[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("irq_set", 64'(irq), 64'd1);
    rd("sticky_b3", BASE + 32'h08, 32'h8);
    @(negedge clk); stat[3] = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); stat[3] = 1'b1;
    wr(BASE + 32'h08, 32'h8, 4'hF);
    rd("sticky_set_wins", BASE + 32'h08, 32'h8);
    wr(BASE + 32'h08, 32'h8, 4'hF);
    rd("sticky_w1c", BASE + 32'h08, 32'h0);
    chk("irq_clr", 64'(irq), 64'd0);

    // Random rise pattern and mask.
    @(negedge clk); stat[31:0] = '0;
    repeat (3) @(negedge clk);
    wr(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    rv = $urandom;
    stat[31:0] = rv;
    repeat (3) @(negedge clk);
    rd("sticky_rand", BASE + 32'h08, rv);
    m32 = $urandom;
    wr(BASE + 32'h10, m32, 4'hF);
    rd("mask_rd", BASE + 32'h10, m32);
    chk("irq_rand", 64'(irq), 64'(|(rv & m32)));

    // Event counter.
    wr(BASE + 32'h0C, 32'h0, 4'hF);
    pulse_evt(5);
    rd("count5", BASE + 32'h0C, 32'd5);
    n = int'($urandom_range(20, 1));
    pulse_evt(n);
    rd("count_rand", BASE + 32'h0C, 32'(5 + n));
    @(negedge clk);
    evt = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h0C; wdat = $urandom; sel = 4'hF;
    @(negedge clk);
    evt = 1'b0;
    chk("count_wr_ack", 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd("count_wr_evt", BASE + 32'h0C, 32'h0);
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.count_q;
    pulse_evt(2);
    rd("count_wrap", BASE + 32'h0C, 32'h0);
    pulse_evt(1);
    rd("count_after_wrap", BASE + 32'h0C, 32'h1);

    // Decode edges.
    xfer(1'b0, BASE + 32'h1000, 32'h0, 4'hF, r32, lat);
    chk("miss_noack", 64'(lat), 64'd0);
    rd("unmapped", BASE + 32'h3C, 32'h0);
    wr(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
    rd("id_ro", BASE + 32'h00, 32'h4850_3335);

    // Synchronous reset clears the bank.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst2_ctrl", 64'(ctrl_o[63:0]), 64'd0);
    chk("rst2_irq", 64'(irq), 64'd0);
    rd("rst2_sticky", BASE + 32'h08, 32'h0);
    rd("rst2_snap", BASE + 32'h88, 32'h0);

`ifdef HP35_DBG_LA_OVERRIDE_EN
    wr(BASE + 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    la_oenb = 32'hFFFF_FFFE; la_data_in = 32'h1;
    #1;
    chk("la_override", 64'(ctrl_o[31:0]), 64'h1);
    rd("la_ctrl0_reg", BASE + 32'h40, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
